// File: rtl/vend_pkg.sv
// vend_pkg: shared states, coin values, item type and price lookup for the vending controller
package vend_pkg;

    typedef enum logic [2:0] {IDLE, CHECK, VEND, CHANGE, CLEAR} vend_state_t;

    typedef logic [1:0] item_t;

    localparam logic [7:0] COIN_5  = 8'd5;
    localparam logic [7:0] COIN_10 = 8'd10;
    localparam logic [7:0] COIN_25 = 8'd25;

    function automatic logic [7:0] price_of(input item_t item, input logic [7:0] p0,
                                            input logic [7:0] p1, input logic [7:0] p2,
                                            input logic [7:0] p3);
        return item == 2'd0 ? p0 : item == 2'd1 ? p1 : item == 2'd2 ? p2 : p3;
    endfunction

endpackage

// File: rtl/vend_controller_change_dispenser.sv
// change_dispenser: greedy 25/10/5 coin payout of a loaded change amount, one coin per ready cycle
module change_dispenser
    import vend_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] load_value,
    input  logic       coin_ready,
    output logic       coin_out_25,
    output logic       coin_out_10,
    output logic       coin_out_5,
    output logic [7:0] change_due,
    output logic       done
);

    logic [7:0] w_coin;
    logic       w_issue;

    assign done    = change_due < COIN_5;
    assign w_issue = coin_ready && !done && !load;
    assign w_coin  = change_due >= COIN_25 ? COIN_25 : change_due >= COIN_10 ? COIN_10 : COIN_5;

    // Load a new amount, or pay the largest coin that fits and deduct it in the same cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            coin_out_25 <= 1'b0;
            coin_out_10 <= 1'b0;
            coin_out_5  <= 1'b0;
            change_due  <= 8'd0;
        end else begin
            coin_out_25 <= w_issue && w_coin == COIN_25;
            coin_out_10 <= w_issue && w_coin == COIN_10;
            coin_out_5  <= w_issue && w_coin == COIN_5;
            change_due  <= load ? load_value : w_issue ? change_due - w_coin : change_due;
        end
    end

endmodule

// File: rtl/vend_controller.sv
// vend_controller: vending transaction sequencer (select/check/vend/change/clear); STOCK_COUNT_EN adds per-item stock counters and sold_out
module vend_controller
    import vend_pkg::*;
#(
    parameter logic [7:0] PRICE_0    = 8'd65,
    parameter logic [7:0] PRICE_1    = 8'd75,
    parameter logic [7:0] PRICE_2    = 8'd100,
    parameter logic [7:0] PRICE_3    = 8'd125,
    parameter logic [3:0] STOCK_INIT = 4'd8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] total,
    input  logic       sel_valid,
    input  logic [1:0] sel_item,
    input  logic       cancel,
    input  logic       vend_ack,
    input  logic       coin_ready,
    output logic       coin_inhibit,
    output logic       clear,
    output logic       vend_req,
    output logic [1:0] vend_item,
    output logic       coin_out_25,
    output logic       coin_out_10,
    output logic       coin_out_5,
    output logic       insufficient,
    output logic [7:0] change_due
`ifdef STOCK_COUNT_EN
    ,
    output logic [3:0] sold_out
`endif
);

    vend_state_t r_state, w_next;
    logic [7:0]  r_snap;
    item_t       r_item;
    logic [7:0]  w_price;
    logic        w_ok;
    logic        w_in_stock;
    logic        w_load;
    logic [7:0]  w_load_value;
    logic        w_insufficient;
    logic        w_done;

    assign w_price = price_of(r_item, PRICE_0, PRICE_1, PRICE_2, PRICE_3);
    assign w_ok    = r_snap >= w_price && w_in_stock;

`ifdef STOCK_COUNT_EN
    logic [3:0] r_stock [4];

    assign w_in_stock = r_stock[r_item] != 4'd0;

    // One stock counter per item, consumed when the mechanism acknowledges a dispense
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) r_stock[i] <= STOCK_INIT;
        end else if (r_state == VEND && vend_ack && r_stock[r_item] != 4'd0) begin
            r_stock[r_item] <= r_stock[r_item] - 4'd1;
        end
    end

    // Flag every item whose counter has run out
    always_comb begin
        sold_out = 4'd0;
        for (int i = 0; i < 4; i++) sold_out[i] = r_stock[i] == 4'd0;
    end
`else
    assign w_in_stock = 1'b1;
`endif

    change_dispenser u_change (
        .clk        (clk),
        .reset      (reset),
        .load       (w_load),
        .load_value (w_load_value),
        .coin_ready (coin_ready && r_state == CHANGE),
        .coin_out_25(coin_out_25),
        .coin_out_10(coin_out_10),
        .coin_out_5 (coin_out_5),
        .change_due (change_due),
        .done       (w_done)
    );

    // Next state plus the change-load and insufficient decisions for this cycle
    always_comb begin
        w_next         = r_state;
        w_load         = 1'b0;
        w_load_value   = 8'd0;
        w_insufficient = 1'b0;
        case (r_state)
            IDLE: begin
                if (cancel) begin
                    w_next       = CHANGE;
                    w_load       = 1'b1;
                    w_load_value = total;
                end else if (sel_valid) begin
                    w_next = CHECK;
                end
            end
            CHECK: begin
                w_next         = w_ok ? VEND : IDLE;
                w_load         = w_ok;
                w_load_value   = w_ok ? r_snap - w_price : 8'd0;
                w_insufficient = !w_ok;
            end
            VEND:   w_next = vend_ack ? CHANGE : VEND;
            CHANGE: begin
                w_next = w_done ? CLEAR : CHANGE;
                w_load = w_done;
            end
            CLEAR:   w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // State register and registered outputs derived from the upcoming state
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_snap       <= 8'd0;
            r_item       <= 2'd0;
            coin_inhibit <= 1'b0;
            clear        <= 1'b0;
            vend_req     <= 1'b0;
            vend_item    <= 2'd0;
            insufficient <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_snap       <= r_state == IDLE && (cancel || sel_valid) ? total : r_snap;
            r_item       <= r_state == IDLE && !cancel && sel_valid ? sel_item : r_item;
            coin_inhibit <= w_next != IDLE;
            clear        <= w_next == CLEAR;
            vend_req     <= w_next == VEND;
            vend_item    <= r_state == CHECK && w_next == VEND ? r_item : vend_item;
            insufficient <= w_insufficient;
        end
    end

endmodule

// File: tb/tb_vend_controller.sv
// tb_vend_controller: directed vectors with hand-computed expectations for vend_controller
module tb_vend_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] total = 8'd0;
    logic       sel_valid = 1'b0;
    logic [1:0] sel_item = 2'd0;
    logic       cancel = 1'b0;
    logic       vend_ack = 1'b0;
    logic       coin_ready = 1'b1;
    logic       coin_inhibit, clear, vend_req, coin_out_25, coin_out_10, coin_out_5, insufficient;
    logic [1:0] vend_item;
    logic [7:0] change_due;
`ifdef STOCK_COUNT_EN
    logic [3:0] sold_out;
`endif
    logic [16:0] outs;

    int vectors = 0;
    int miscompares = 0;

    vend_controller dut (
        .clk         (clk),
        .reset       (reset),
        .total       (total),
        .sel_valid   (sel_valid),
        .sel_item    (sel_item),
        .cancel      (cancel),
        .vend_ack    (vend_ack),
        .coin_ready  (coin_ready),
        .coin_inhibit(coin_inhibit),
        .clear       (clear),
        .vend_req    (vend_req),
        .vend_item   (vend_item),
        .coin_out_25 (coin_out_25),
        .coin_out_10 (coin_out_10),
        .coin_out_5  (coin_out_5),
        .insufficient(insufficient),
        .change_due  (change_due)
`ifdef STOCK_COUNT_EN
        ,
        .sold_out    (sold_out)
`endif
    );

    assign outs = {coin_inhibit, clear, vend_req, vend_item, coin_out_25, coin_out_10,
                   coin_out_5, insufficient, change_due};

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive a selection for one cycle; returns in the CHECK cycle
    task automatic select(input logic [7:0] t, input logic [1:0] item);
        total     = t;
        sel_item  = item;
        sel_valid = 1'b1;
        @(negedge clk);
        sel_valid = 1'b0;
    endtask

    task automatic ack();
        vend_ack = 1'b1;
        @(negedge clk);
        vend_ack = 1'b0;
    endtask

    // Follow the CHANGE/CLEAR tail until coin_inhibit drops; coins encoded base 4 (25->3, 10->2, 5->1)
    task automatic drain(input string tag, input int exp_seq, input bit toggle);
        int   seq = 0, clrs = 0, bad = 0, cyc = 0, last = -1, clrc = -1;
        logic prev = coin_ready;
        while (coin_inhibit && cyc < 100) begin
            if (int'(coin_out_25) + int'(coin_out_10) + int'(coin_out_5) > 1) bad++;
            if ((coin_out_25 || coin_out_10 || coin_out_5) && !prev) bad++;
            if (coin_out_25) seq = seq * 4 + 3;
            if (coin_out_10) seq = seq * 4 + 2;
            if (coin_out_5)  seq = seq * 4 + 1;
            if (coin_out_25 || coin_out_10 || coin_out_5) last = cyc;
            if (clear) begin
                clrs++;
                clrc = cyc;
                if (change_due != 8'd0) bad++;
            end
            coin_ready = toggle ? ~coin_ready : 1'b1;
            prev = coin_ready;
            @(negedge clk);
            cyc++;
        end
        coin_ready = 1'b1;
        check({tag, "_idle"}, coin_inhibit, 0);
        check({tag, "_coins"}, seq, exp_seq);
        check({tag, "_clears"}, clrs, 1);
        check({tag, "_clear_lat"}, clrc, last >= 0 ? last + 1 : 1);
        check({tag, "_rules"}, bad, 0);
        check({tag, "_due"}, change_due, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_outs", outs, 0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_outs", outs, 0);

        select(8'd75, 2'd0);
        check("t1_check_inhibit", coin_inhibit, 1);
        check("t1_check_noreq", vend_req, 0);
        @(negedge clk);
        check("t1_vend_req", vend_req, 1);
        check("t1_vend_item", vend_item, 0);
        check("t1_due", change_due, 10);
        cancel = 1'b1;
        sel_valid = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        sel_valid = 1'b0;
        check("t1_hold_req", vend_req, 1);
        check("t1_hold_due", change_due, 10);
        ack();
        check("t1_req_drop", vend_req, 0);
        drain("t1", 2, 1'b0);

        select(8'd50, 2'd0);
        @(negedge clk);
        check("t2_insuff", insufficient, 1);
        check("t2_noreq", vend_req, 0);
        check("t2_noclear", clear, 0);
        check("t2_idle", coin_inhibit, 0);
        @(negedge clk);
        check("t2_pulse", insufficient, 0);

        select(8'd74, 2'd1);
        @(negedge clk);
        check("t2b_insuff", insufficient, 1);
        @(negedge clk);

        total = 8'd40;
        cancel = 1'b1;
        sel_valid = 1'b1;
        sel_item = 2'd1;
        @(negedge clk);
        cancel = 1'b0;
        sel_valid = 1'b0;
        check("t3_inhibit", coin_inhibit, 1);
        check("t3_due", change_due, 40);
        drain("t3", 57, 1'b0);

        select(8'd100, 2'd2);
        @(negedge clk);
        check("t4_req", vend_req, 1);
        check("t4_item", vend_item, 2);
        check("t4_due", change_due, 0);
        ack();
        drain("t4", 0, 1'b0);

        select(8'd255, 2'd0);
        @(negedge clk);
        check("t5_due", change_due, 190);
        ack();
        drain("t5", 262137, 1'b1);

        select(8'd130, 2'd3);
        @(negedge clk);
        check("t6_item", vend_item, 3);
        check("t6_due", change_due, 5);
        ack();
        drain("t6", 1, 1'b0);

        select(8'd80, 2'd1);
        @(negedge clk);
        check("t7_req", vend_req, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("t7_reset_outs", outs, 0);
        @(negedge clk);
        check("t7_no_clear", outs, 0);
        select(8'd65, 2'd0);
        @(negedge clk);
        check("t8_req", vend_req, 1);
        check("t8_due", change_due, 0);
        ack();
        drain("t8", 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
